// File: rtl/event_encoder8to3_pkg.sv
// Shared types and default sizing for the event encoder and its benches.
package event_encoder8to3_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_CODE_W = $clog2(DEF_WIDTH);

endpackage

// File: rtl/event_encoder8to3_prio.sv
// Combinational priority encoder: mask -> index of the winning set bit, plus any_set.
module prio_encoder
   import event_encoder8to3_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int CODE_W       = $clog2(WIDTH),
   parameter bit PRIORITY_LSB = 1'b1
) (
   input  logic [WIDTH-1:0]  mask,
   output logic [CODE_W-1:0] index,
   output logic              any_set
);

   // The last matching assignment wins, so the scan runs toward the favoured end.
   always_comb begin
      index   = '0;
      any_set = |mask;
      if (PRIORITY_LSB) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) index = CODE_W'(i);
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (mask[i]) index = CODE_W'(i);
         end
      end
   end

endmodule

// File: rtl/event_encoder8to3.sv
// Sequential event encoder: latches event pulses into a pending mask and
// hands out one pending index per valid/ready handshake in priority order.
//
//   state | meaning
//   IDLE  | no offer up; loads the top-priority pending index when pending != 0
//   OFFER | code_out valid and held until accepted; chains to the next pending index
module event_encoder8to3
   import event_encoder8to3_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int CODE_W       = $clog2(WIDTH),
   parameter bit PRIORITY_LSB = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  data_in,
   input  logic              clear,
   input  logic              ready_in,
   output logic [CODE_W-1:0] code_out,
   output logic              valid_out,
   output logic [WIDTH-1:0]  pending,
   output logic              overflow
);

   state_t            state;
   logic              accept;
   logic [WIDTH-1:0]  ack_mask;
   logic [WIDTH-1:0]  rem;
   logic [CODE_W-1:0] pend_idx;
   logic [CODE_W-1:0] rem_idx;
   logic              pend_any;
   logic              rem_any;

   assign accept   = valid_out & ready_in;
   assign ack_mask = accept ? (WIDTH'(1) << code_out) : '0;
   assign rem      = pending & ~ack_mask;

   prio_encoder #(
      .WIDTH        (WIDTH),
      .CODE_W       (CODE_W),
      .PRIORITY_LSB (PRIORITY_LSB)
   ) u_prio_pend (
      .mask    (pending),
      .index   (pend_idx),
      .any_set (pend_any)
   );

   prio_encoder #(
      .WIDTH        (WIDTH),
      .CODE_W       (CODE_W),
      .PRIORITY_LSB (PRIORITY_LSB)
   ) u_prio_rem (
      .mask    (rem),
      .index   (rem_idx),
      .any_set (rem_any)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         pending   <= '0;
         code_out  <= '0;
         valid_out <= 1'b0;
         overflow  <= 1'b0;
      end else if (clear) begin
         // A flush drops same-cycle events, so they cannot be duplicates either.
         state     <= IDLE;
         pending   <= '0;
         valid_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         pending  <= rem | data_in;
         overflow <= |(data_in & rem);
         case (state)
            IDLE: begin
               if (pend_any) begin
                  code_out  <= pend_idx;
                  valid_out <= 1'b1;
                  state     <= OFFER;
               end
            end
            OFFER: begin
               // Events arriving on this edge are not in rem; they wait for the next decision.
               if (accept) begin
                  if (rem_any) begin
                     code_out <= rem_idx;
                  end else begin
                     valid_out <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               valid_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_event_encoder8to3.sv
// Self-checking bench for event_encoder8to3: per-cycle vector table plus directed sequences.
module tb_event_encoder8to3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic       ready_in;
   logic [7:0] data_in;
   logic [2:0] code_out, code_msb;
   logic       valid_out, valid_msb;
   logic [7:0] pending, pending_msb;
   logic       overflow, overflow_msb;

   int total_cnt = 0;
   int pass_cnt  = 0;

   always #5 clk = ~clk;

   event_encoder8to3 #(.WIDTH(8), .CODE_W(3), .PRIORITY_LSB(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .clear     (clear),
      .ready_in  (ready_in),
      .code_out  (code_out),
      .valid_out (valid_out),
      .pending   (pending),
      .overflow  (overflow)
   );

   event_encoder8to3 #(.WIDTH(8), .CODE_W(3), .PRIORITY_LSB(1'b0)) dut_msb (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .clear     (clear),
      .ready_in  (ready_in),
      .code_out  (code_msb),
      .valid_out (valid_msb),
      .pending   (pending_msb),
      .overflow  (overflow_msb)
   );

   typedef struct {
      logic       rst_n;
      logic       clear;
      logic       ready;
      logic [7:0] data;
      logic       exp_valid;
      logic [2:0] exp_code;
      logic [7:0] exp_pend;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic c, input logic rd, input logic [7:0] d,
                      input logic ev, input logic [2:0] ec, input logic [7:0] ep, input logic eo);
      vec_t v;
      v.rst_n = r; v.clear = c; v.ready = rd; v.data = d;
      v.exp_valid = ev; v.exp_code = ec; v.exp_pend = ep; v.exp_ovf = eo;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Inputs applied now are sampled at the next edge; outputs read 1 time unit after it.
   task automatic step(input logic r, input logic c, input logic rd, input logic [7:0] d);
      rst_n = r; clear = c; ready_in = rd; data_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic ev, input logic [2:0] ec,
                             input logic [7:0] ep, input logic eo, input bit chk_code);
      check({tag, " valid"}, int'(valid_out), int'(ev));
      check({tag, " pending"}, int'(pending), int'(ep));
      check({tag, " overflow"}, int'(overflow), int'(eo));
      if (chk_code) check({tag, " code"}, int'(code_out), int'(ec));
   endtask

   int seen[8];
   int ovf_seen;

   initial begin
      rst_n = 1'b0; clear = 1'b0; ready_in = 1'b0; data_in = 8'h00;

      // reset with events on every line
      add(0,0,0,8'hFF, 0,0,8'h00,0);
      add(0,0,0,8'hFF, 0,0,8'h00,0);
      // single event on line 5
      add(1,0,1,8'h20, 0,0,8'h00,0);
      add(1,0,1,8'h00, 0,0,8'h20,0);
      add(1,0,1,8'h00, 1,5,8'h20,0);
      add(1,0,1,8'h00, 0,0,8'h00,0);
      add(1,0,1,8'h00, 0,0,8'h00,0);
      // burst 1001_0010, lowest index first
      add(1,0,1,8'h92, 0,0,8'h00,0);
      add(1,0,1,8'h00, 0,0,8'h92,0);
      add(1,0,1,8'h00, 1,1,8'h92,0);
      add(1,0,1,8'h00, 1,4,8'h90,0);
      add(1,0,1,8'h00, 1,7,8'h80,0);
      add(1,0,1,8'h00, 0,0,8'h00,0);
      // duplicate on a pending line -> overflow, one code only
      add(1,0,0,8'h08, 0,0,8'h00,0);
      add(1,0,0,8'h08, 0,0,8'h08,0);
      add(1,0,0,8'h00, 1,3,8'h08,1);
      add(1,0,1,8'h00, 1,3,8'h08,0);
      add(1,0,1,8'h00, 0,0,8'h00,0);
      add(1,0,1,8'h00, 0,0,8'h00,0);
      // re-arm on the accept edge -> second code 3, no overflow
      add(1,0,1,8'h08, 0,0,8'h00,0);
      add(1,0,1,8'h00, 0,0,8'h08,0);
      add(1,0,1,8'h08, 1,3,8'h08,0);
      add(1,0,1,8'h00, 0,0,8'h08,0);
      add(1,0,1,8'h00, 1,3,8'h08,0);
      add(1,0,1,8'h00, 0,0,8'h00,0);

      // Each row's expectations describe the outputs after the edge that samples the row before it.
      for (int i = 0; i < vecs.size(); i++) begin
         if (i > 0)
            expect_out($sformatf("row%0d", i), vecs[i].exp_valid, vecs[i].exp_code,
                       vecs[i].exp_pend, vecs[i].exp_ovf,
                       vecs[i].exp_valid || !vecs[i-1].rst_n);
         step(vecs[i].rst_n, vecs[i].clear, vecs[i].ready, vecs[i].data);
      end

      // backpressure: code 6 held while a higher-priority event arrives
      step(1,0,0,8'h40); expect_out("bp0", 0,0,8'h40,0,0);
      step(1,0,0,8'h00); expect_out("bp1", 1,6,8'h40,0,1);
      step(1,0,0,8'h01); expect_out("bp2", 1,6,8'h41,0,1);
      step(1,0,0,8'h00); expect_out("bp3", 1,6,8'h41,0,1);
      step(1,0,1,8'h00); expect_out("bp4", 1,0,8'h01,0,1);
      step(1,0,1,8'h00); expect_out("bp5", 0,0,8'h00,0,0);

      // clear mid-offer, with a same-cycle event that must be dropped
      step(1,0,0,8'hF0); expect_out("clr0", 0,0,8'hF0,0,0);
      step(1,0,0,8'h00); expect_out("clr1", 1,4,8'hF0,0,1);
      step(1,1,1,8'h01); expect_out("clr2", 0,0,8'h00,0,0);
      step(1,0,1,8'h00); expect_out("clr3", 0,0,8'h00,0,0);

      // reset mid-burst
      step(1,0,1,8'hF0); expect_out("rst0", 0,0,8'hF0,0,0);
      step(1,0,1,8'h00); expect_out("rst1", 1,4,8'hF0,0,1);
      step(1,0,1,8'h00); expect_out("rst2", 1,5,8'hE0,0,1);
      step(0,0,1,8'h00); expect_out("rst3", 0,0,8'h00,0,1);
      step(1,0,1,8'h00); expect_out("rst4", 0,0,8'h00,0,0);
      step(1,0,1,8'h00); expect_out("rst5", 0,0,8'h00,0,0);

      // highest-index-first instance on the same burst
      step(1,0,1,8'h92);
      step(1,0,1,8'h00);
      check("msb valid0", int'(valid_msb), 1); check("msb code0", int'(code_msb), 7);
      step(1,0,1,8'h00);
      check("msb valid1", int'(valid_msb), 1); check("msb code1", int'(code_msb), 4);
      step(1,0,1,8'h00);
      check("msb valid2", int'(valid_msb), 1); check("msb code2", int'(code_msb), 1);
      step(1,0,1,8'h00);
      check("msb valid3", int'(valid_msb), 0); check("msb pending", int'(pending_msb), 0);

      // loopback: one-hot decode of every code, each must come back exactly once
      for (int k = 0; k < 8; k++) seen[k] = 0;
      ovf_seen = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         logic [7:0] d;
         d = (cyc < 8) ? 8'(1 << cyc) : 8'h00;
         step(1,0,1,d);
         if (valid_out) seen[code_out]++;
         if (overflow) ovf_seen++;
      end
      for (int k = 0; k < 8; k++) check($sformatf("loop code%0d count", k), seen[k], 1);
      check("loop overflow", ovf_seen, 0);
      check("loop final valid", int'(valid_out), 0);
      check("loop final pending", int'(pending), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
